// File: rtl/register_alias_table_pkg.sv
// rename_pkg: rename-stage types and sizes shared by the RAT, ROB and reservation stations.
package rename_pkg;
    localparam int NUM_ARCH_REGS = 64;
    localparam int TAG_WIDTH = 4;
    localparam int ROB_DEPTH = 1 << TAG_WIDTH;
    localparam logic [5:0] ZERO_REG = 6'd0;
    typedef logic [TAG_WIDTH-1:0] tag_t;
    typedef logic [ROB_DEPTH-1:0] tag_vec_t;
    typedef logic [5:0] areg_t;
    typedef struct packed {
        logic busy;
        tag_t tag;
    } rat_entry_t;
    typedef enum logic {NORMAL, RECOVER} rat_state_e;
endpackage

// File: rtl/register_alias_table_if.sv
// register_alias_table_if: dispatch, lookup, CDB, commit and flush signals of the rename stage.
interface register_alias_table_if;
    import rename_pkg::*;
    logic dispatch_valid, dispatch_ready, rob_empty_spot, dst_wr;
    tag_t rob_tag;
    areg_t dst_reg, src_a_reg, src_b_reg;
    logic src_a_busy, src_a_ready, src_b_busy, src_b_ready;
    tag_t src_a_tag, src_b_tag;
    logic cdb_valid;
    tag_t cdb_tag;
    logic commit_valid;
    areg_t commit_reg;
    tag_t commit_tag;
    logic flush;
    logic [6:0] busy_count;
    modport master (
        output dispatch_valid, rob_empty_spot, rob_tag, dst_wr, dst_reg, src_a_reg, src_b_reg,
               cdb_valid, cdb_tag, commit_valid, commit_reg, commit_tag, flush,
        input dispatch_ready, src_a_busy, src_a_tag, src_a_ready, src_b_busy, src_b_tag, src_b_ready,
              busy_count
    );
    modport slave (
        input dispatch_valid, rob_empty_spot, rob_tag, dst_wr, dst_reg, src_a_reg, src_b_reg,
              cdb_valid, cdb_tag, commit_valid, commit_reg, commit_tag, flush,
        output dispatch_ready, src_a_busy, src_a_tag, src_a_ready, src_b_busy, src_b_tag, src_b_ready,
               busy_count
    );
endinterface

// File: rtl/register_alias_table_ready_table.sv
// rat_ready_table: per-tag result-ready bits set by the CDB, cleared on allocation, with CDB bypass.
module rat_ready_table
    import rename_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     set,
    input  tag_t     set_tag,
    input  logic     clr,
    input  tag_t     clr_tag,
    input  logic     flush,
    output tag_vec_t ready
);
    tag_vec_t rdy, set_vec, clr_vec;
    assign set_vec = set ? tag_vec_t'(1) << set_tag : '0;
    assign clr_vec = clr ? tag_vec_t'(1) << clr_tag : '0;
    assign ready = rdy | set_vec;
    // a broadcast racing a re-allocation of its tag is stale, so the clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy <= '0;
        else rdy <= flush ? '0 : (rdy | set_vec) & ~clr_vec;
    end
endmodule

// File: rtl/register_alias_table.sv
// register_alias_table: maps architectural registers to the ROB tag of their youngest in-flight producer.
module register_alias_table
    import rename_pkg::*;
(
    input logic clk,
    input logic rst_n,
    register_alias_table_if.slave rif
);
    rat_entry_t map [NUM_ARCH_REGS];
    rat_state_e state;
    logic [6:0] count;
    logic fire, rename, commit_hit, inc, dec;
    rat_entry_t ea, eb;
    tag_vec_t ready;
    assign rif.dispatch_ready = rif.rob_empty_spot & ~rif.flush & (state == NORMAL);
    assign fire = rif.dispatch_valid & rif.dispatch_ready;
    assign rename = fire & rif.dst_wr & (rif.dst_reg != ZERO_REG);
    assign commit_hit = rif.commit_valid & map[rif.commit_reg].busy & (map[rif.commit_reg].tag == rif.commit_tag);
    assign inc = rename & ~map[rif.dst_reg].busy;
    assign dec = commit_hit & ~(rename & (rif.dst_reg == rif.commit_reg));
    assign ea = (rif.src_a_reg == ZERO_REG) ? '0 : map[rif.src_a_reg];
    assign eb = (rif.src_b_reg == ZERO_REG) ? '0 : map[rif.src_b_reg];
    assign rif.src_a_busy = ea.busy;
    assign rif.src_a_tag = ea.busy ? ea.tag : '0;
    assign rif.src_a_ready = ~ea.busy | ready[rif.src_a_tag];
    assign rif.src_b_busy = eb.busy;
    assign rif.src_b_tag = eb.busy ? eb.tag : '0;
    assign rif.src_b_ready = ~eb.busy | ready[rif.src_b_tag];
    assign rif.busy_count = count;
    rat_ready_table u_ready (
        .clk(clk), .rst_n(rst_n),
        .set(rif.cdb_valid), .set_tag(rif.cdb_tag),
        .clr(rename), .clr_tag(rif.rob_tag),
        .flush(rif.flush), .ready(ready)
    );
    // rename is written after commit so it wins when both hit the same register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) map[i] <= '0;
            state <= NORMAL;
            count <= '0;
        end else if (rif.flush) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) map[i] <= '0;
            state <= RECOVER;
            count <= '0;
        end else begin
            state <= NORMAL;
            if (commit_hit) map[rif.commit_reg].busy <= 1'b0;
            if (rename) map[rif.dst_reg] <= '{busy: 1'b1, tag: rif.rob_tag};
            count <= count + 7'(inc) - 7'(dec);
        end
    end
endmodule

// File: tb/tb_register_alias_table.sv
// tb_register_alias_table: directed spec scenarios plus random traffic against an array-based model.
module tb_register_alias_table;
    import rename_pkg::*;
    logic clk = 0;
    logic rst_n = 0;
    int total = 0;
    int bad = 0;
    bit m_busy [64];
    int m_tag [64];
    bit m_rdy [16];
    bit m_rec;
    register_alias_table_if rif ();
    register_alias_table dut (.clk(clk), .rst_n(rst_n), .rif(rif));
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) begin m_busy[i] = 0; m_tag[i] = 0; end
        foreach (m_rdy[i]) m_rdy[i] = 0;
        m_rec = 0;
    endtask

    function automatic int m_count();
        int n = 0;
        foreach (m_busy[i]) n += m_busy[i];
        return n;
    endfunction

    function automatic bit m_dready();
        return rif.rob_empty_spot && !rif.flush && !m_rec;
    endfunction

    task automatic probe_src(input string nm, input int r, input logic b, input logic [3:0] t, input logic rd);
        bit eb;
        int et;
        eb = r != 0 && m_busy[r];
        et = eb ? m_tag[r] : 0;
        check({nm, "_busy"}, 32'(b), 32'(eb));
        check({nm, "_tag"}, 32'(t), 32'(et));
        check({nm, "_ready"}, 32'(rd), 32'(!eb || m_rdy[et] || (rif.cdb_valid && int'(rif.cdb_tag) == et)));
    endtask

    task automatic probe();
        #1;
        check("dispatch_ready", 32'(rif.dispatch_ready), 32'(m_dready()));
        check("busy_count", 32'(rif.busy_count), 32'(m_count()));
        probe_src("src_a", int'(rif.src_a_reg), rif.src_a_busy, rif.src_a_tag, rif.src_a_ready);
        probe_src("src_b", int'(rif.src_b_reg), rif.src_b_busy, rif.src_b_tag, rif.src_b_ready);
    endtask

    task automatic tick();
        bit fire;
        int d, c;
        fire = rif.dispatch_valid && m_dready();
        d = int'(rif.dst_reg);
        c = int'(rif.commit_reg);
        @(posedge clk);
        if (rif.flush) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            foreach (m_rdy[i]) m_rdy[i] = 0;
            m_rec = 1;
        end else begin
            m_rec = 0;
            if (rif.cdb_valid) m_rdy[rif.cdb_tag] = 1;
            if (rif.commit_valid && m_busy[c] && m_tag[c] == int'(rif.commit_tag)) m_busy[c] = 0;
            if (fire && rif.dst_wr && d != 0) begin
                m_busy[d] = 1;
                m_tag[d] = int'(rif.rob_tag);
                m_rdy[rif.rob_tag] = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rif.dispatch_valid = 0; rif.rob_empty_spot = 1; rif.rob_tag = 0; rif.dst_wr = 0; rif.dst_reg = 0;
        rif.src_a_reg = 0; rif.src_b_reg = 0; rif.cdb_valid = 0; rif.cdb_tag = 0;
        rif.commit_valid = 0; rif.commit_reg = 0; rif.commit_tag = 0; rif.flush = 0;
    endtask

    task automatic disp(input int dst, input int tag);
        rif.dispatch_valid = 1; rif.dst_wr = 1; rif.dst_reg = areg_t'(dst); rif.rob_tag = tag_t'(tag);
    endtask

    task automatic cmt(input int r, input int tag);
        rif.commit_valid = 1; rif.commit_reg = areg_t'(r); rif.commit_tag = tag_t'(tag);
    endtask

    task automatic rand_cycle();
        int cr;
        rif.dispatch_valid = $urandom_range(0, 9) < 7;
        rif.rob_empty_spot = $urandom_range(0, 19) < 17;
        rif.rob_tag = tag_t'($urandom);
        rif.dst_wr = $urandom_range(0, 9) < 8;
        rif.dst_reg = areg_t'($urandom_range(0, 15));
        rif.src_a_reg = areg_t'($urandom_range(0, 15));
        rif.src_b_reg = areg_t'($urandom_range(0, 15));
        rif.cdb_valid = $urandom_range(0, 1);
        rif.cdb_tag = tag_t'($urandom);
        cr = $urandom_range(0, 15);
        rif.commit_valid = $urandom_range(0, 9) < 4;
        rif.commit_reg = areg_t'(cr);
        rif.commit_tag = $urandom_range(0, 3) != 0 ? tag_t'(m_tag[cr]) : tag_t'($urandom);
        rif.flush = $urandom_range(0, 39) == 0;
        probe();
        tick();
    endtask

    initial begin
        idle();
        model_reset();
        rif.src_a_reg = 5;
        #12;
        check("rst_busy_count", 32'(rif.busy_count), 0);
        check("rst_a_ready", 32'(rif.src_a_ready), 1);
        @(negedge clk);
        rst_n = 1;
        probe();
        rif.rob_empty_spot = 0;
        probe();
        check("res_dready_low", 32'(rif.dispatch_ready), 0);
        tick();
        idle(); disp(5, 3); probe(); tick();
        idle(); rif.src_a_reg = 5; probe();
        check("ren_a_tag", 32'(rif.src_a_tag), 3);
        check("ren_a_ready", 32'(rif.src_a_ready), 0);
        tick();
        rif.cdb_valid = 1; rif.cdb_tag = 3; probe();
        check("cdb_bypass", 32'(rif.src_a_ready), 1);
        tick();
        idle(); rif.src_a_reg = 5; probe();
        check("cdb_held", 32'(rif.src_a_ready), 1);
        tick();
        idle(); disp(5, 3); probe(); tick();
        idle(); disp(5, 7); probe(); tick();
        idle(); cmt(5, 3); rif.src_a_reg = 5; probe(); tick();
        idle(); rif.src_a_reg = 5; probe();
        check("stale_commit_tag", 32'(rif.src_a_tag), 7);
        check("stale_commit_cnt", 32'(rif.busy_count), 1);
        cmt(5, 7); tick();
        idle(); rif.src_a_reg = 5; probe();
        check("commit_cnt", 32'(rif.busy_count), 0);
        disp(9, 2); tick();
        idle(); cmt(9, 2); disp(9, 8); probe(); tick();
        idle(); rif.src_a_reg = 9; probe();
        check("cr_same_tag", 32'(rif.src_a_tag), 8);
        check("cr_same_cnt", 32'(rif.busy_count), 1);
        tick();
        for (int r = 1; r <= 4; r++) begin idle(); disp(r, r + 10); probe(); tick(); end
        idle(); rif.flush = 1; disp(6, 1); probe();
        check("flush_dready", 32'(rif.dispatch_ready), 0);
        tick();
        idle(); disp(6, 1); rif.src_a_reg = 2; rif.src_b_reg = 9; probe();
        check("recover_dready", 32'(rif.dispatch_ready), 0);
        check("flush_cnt", 32'(rif.busy_count), 0);
        tick();
        idle(); disp(0, 4); probe(); tick();
        idle(); rif.rob_empty_spot = 0; disp(7, 4); probe(); tick();
        idle(); rif.src_a_reg = 7; rif.src_b_reg = 0; probe();
        check("no_spot_busy", 32'(rif.src_a_busy), 0);
        tick();
        for (int i = 0; i < 2000; i++) rand_cycle();
        idle(); disp(12, 5); probe();
        #2 rst_n = 0;
        #1;
        model_reset();
        check("midrst_cnt", 32'(rif.busy_count), 0);
        @(negedge clk);
        rst_n = 1;
        idle(); rif.src_a_reg = 12; probe(); tick();
        for (int i = 0; i < 500; i++) rand_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
